cache_set_assoc: RTL and testbench
==================================

CACHE_SET_ASSOC -- requirements
Module: cache_set_assoc

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, address width in bits.
REQ-002 Parameter DATA_WIDTH, default 32, word and line width in bits (one word per line); power of 2, >= 8.
REQ-003 Parameter SET_NUM, default 4, number of sets; power of 2, >= 2.
REQ-004 Parameter WAY_NUM, default 4, ways per set; power of 2, >= 2.
REQ-005 Parameter POLICY, default 0, replacement policy: 0 = FIFO, 1 = LRU.
REQ-006 Derived widths: OFF = log2(DATA_WIDTH/8), IDX = log2(SET_NUM), TAG = ADDR_WIDTH-IDX-OFF; index = rc_Addr[IDX+OFF-1:OFF].
REQ-007 CLK  in  1  single clock; all state on its rising edge.
REQ-008 Reset  in  1  asynchronous, active-low reset.
REQ-009 rc_Valid  in  1  request present; held stable until rc_Done.
REQ-010 rc_RW  in  1  0 = read, 1 = write.
REQ-011 rc_Addr  in  ADDR_WIDTH  request byte address.
REQ-012 rc_WriteData  in  DATA_WIDTH  write data.
REQ-013 rc_ReadData  out  DATA_WIDTH  read data, valid while rc_Done = 1.
REQ-014 rc_Done  out  1  one-cycle completion pulse.
REQ-015 rc_Hit  out  1  qualifies rc_Done: 1 = hit, 0 = miss.
REQ-016 cm_ReadValid / cm_ReadAddr / cm_ReadReady / cm_ReadData  out 1 / out ADDR_WIDTH / in 1 / in DATA_WIDTH  line fill channel.
REQ-017 cm_WriteValid / cm_WriteAddr / cm_WriteData / cm_WriteReady  out 1 / out ADDR_WIDTH / out DATA_WIDTH / in 1  write-back channel.

Function
REQ-018 The block SHALL be write-back, write-allocate, with per-way valid bit, dirty bit, tag and data per set.
REQ-019 The FSM SHALL have states IDLE, COMPARE, WBACK, FILL, DONE.
REQ-020 IDLE: rc_Valid = 1 SHALL latch rc_RW, rc_Addr and rc_WriteData, then go to COMPARE next cycle.
REQ-021 COMPARE hit (a valid way with matching tag): read returns the way data; write stores data and sets dirty. rc_Done = 1 and rc_Hit = 1 this cycle, then IDLE. Hit latency is 2 cycles from acceptance.
REQ-022 COMPARE miss: select a victim; go to WBACK if the victim is valid and dirty, else FILL.
REQ-023 Victim selection SHALL pick the lowest-index invalid way; if all ways are valid, FIFO uses the per-set round-robin pointer and LRU uses the way with maximum age.
REQ-024 WBACK SHALL hold cm_WriteValid = 1, cm_WriteAddr = {victim tag, index, OFF zeros} and cm_WriteData = victim data stable until the cycle cm_WriteReady = 1, then go to FILL.
REQ-025 FILL SHALL hold cm_ReadValid = 1 and cm_ReadAddr = {tag, index, OFF zeros} until the cycle cm_ReadReady = 1.
REQ-026 On that FILL cycle, the victim way SHALL be installed: valid = 1; read: data = cm_ReadData, dirty = 0; write: data = latched rc_WriteData, dirty = 1. Then go to DONE.
REQ-027 DONE SHALL pulse rc_Done = 1 with rc_Hit = 0; rc_ReadData = the installed word for reads. Then go to IDLE.
REQ-028 A ready input arriving in the same cycle its valid is first raised SHALL complete the transfer that cycle.
REQ-029 Ready inputs arriving while the matching valid is low SHALL be ignored.
REQ-030 FIFO: the set pointer SHALL advance by 1 modulo WAY_NUM only on a fill into a full set.
REQ-031 LRU: per-way ages of log2(WAY_NUM) bits. On a hit or install, the accessed way goes to 0 and valid ways younger than its old age increment. Ages in a set SHALL stay distinct among valid ways.
REQ-032 cm_ReadValid and cm_WriteValid SHALL never be 1 in the same cycle.
REQ-033 Outputs other than the cm_ channel address/data SHALL be 0 outside the states that drive them.

Reset
REQ-034 Asserting Reset (low), including mid-operation, SHALL immediately force: state IDLE; all valid, dirty, FIFO pointers and LRU ages 0; rc_Done, rc_Hit, cm_ReadValid, cm_WriteValid 0; rc_ReadData 0. Any in-flight request is dropped, with no rc_Done.
REQ-035 Data and tag arrays need not be reset.

Verification (defaults: OFF=2, IDX=2, TAG=28)
REQ-036 After reset, read 0x10 with memory returning 0xAAAA0001 -> FILL to 0x10; rc_Done, rc_Hit = 0, data 0xAAAA0001. Re-read -> rc_Done 2 cycles after acceptance, rc_Hit = 1, same data, no cm_ activity.
REQ-037 Write 0xDEAD to 0x20 (miss) -> fill, no memory write. Fill 0x60, 0xA0, 0xE0, then 0x120 into set 0 -> WBACK with cm_WriteAddr 0x20, data 0xDEAD before FILL 0x120.
REQ-038 FIFO, set 1 filled with 0x04, 0x14, 0x24, 0x34; read 0x04 (hit); miss 0x44 -> evicts way 0 (0x04). LRU, same sequence -> evicts 0x14.
REQ-039 Hold cm_WriteReady low 5 cycles in WBACK -> address and data stable, no cm_ReadValid. Give cm_ReadReady = 1 in the first FILL cycle -> completes that cycle.
REQ-040 Assert Reset in FILL -> cm_ReadValid drops immediately, no rc_Done. Re-read of any prior address after reset -> miss.

Source files
------------

// File: rtl/cache_set_assoc.sv
// Write-back, write-allocate set-associative cache with FIFO or LRU replacement; hits complete 2 cycles from acceptance.
// Misses wait as long as needed on the cm_ valid/ready channels; the requester holds rc_Valid until rc_Done.
module cache_set_assoc #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SET_NUM    = 4,
  parameter int WAY_NUM    = 4,
  parameter int POLICY     = 0
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  rc_Valid,
  input  logic                  rc_RW,
  input  logic [ADDR_WIDTH-1:0] rc_Addr,
  input  logic [DATA_WIDTH-1:0] rc_WriteData,
  output logic [DATA_WIDTH-1:0] rc_ReadData,
  output logic                  rc_Done,
  output logic                  rc_Hit,
  output logic                  cm_ReadValid,
  output logic [ADDR_WIDTH-1:0] cm_ReadAddr,
  input  logic                  cm_ReadReady,
  input  logic [DATA_WIDTH-1:0] cm_ReadData,
  output logic                  cm_WriteValid,
  output logic [ADDR_WIDTH-1:0] cm_WriteAddr,
  output logic [DATA_WIDTH-1:0] cm_WriteData,
  input  logic                  cm_WriteReady
);
  localparam int OFF = $clog2(DATA_WIDTH / 8);
  localparam int IDX = $clog2(SET_NUM);
  localparam int TAG = ADDR_WIDTH - IDX - OFF;
  localparam int WW  = $clog2(WAY_NUM);

  typedef enum logic [2:0] {IDLE, COMPARE, WBACK, FILL, DONE} state_t;

  state_t                r_state;
  logic [WAY_NUM-1:0]    r_valid    [SET_NUM];
  logic [WAY_NUM-1:0]    r_dirty    [SET_NUM];
  logic [WW-1:0]         r_age      [SET_NUM][WAY_NUM];
  logic [WW-1:0]         r_fifo_ptr [SET_NUM];
  logic [TAG-1:0]        r_tag      [SET_NUM][WAY_NUM];
  logic [DATA_WIDTH-1:0] r_data     [SET_NUM][WAY_NUM];

  logic                  r_rw;
  logic [TAG-1:0]        r_req_tag;
  logic [IDX-1:0]        r_idx;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [WW-1:0]         r_victim;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic          w_hit;
  logic [WW-1:0] w_hit_way;
  logic          w_full;
  logic [WW-1:0] w_victim;
  logic [WW-1:0] w_max_way;
  logic [WW-1:0] w_max_age;
  logic          w_touch;
  logic [WW-1:0] w_touch_way;
  logic [WW-1:0] w_touch_old;
  logic          w_fill_done;

  if (OFF > 0) begin : g_off_unused
    logic w_unused_off;
    assign w_unused_off = &{1'b0, rc_Addr[OFF-1:0]};
  end

  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int w = 0; w < WAY_NUM; w++) begin
      if (r_valid[r_idx][w] && (r_tag[r_idx][w] == r_req_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WW'(w);
      end
    end
  end

  // Invalid ways win (lowest index first); otherwise the policy decides.
  always_comb begin
    w_full    = &r_valid[r_idx];
    w_max_way = '0;
    w_max_age = r_age[r_idx][0];
    for (int w = 1; w < WAY_NUM; w++) begin
      if (r_age[r_idx][w] > w_max_age) begin
        w_max_age = r_age[r_idx][w];
        w_max_way = WW'(w);
      end
    end
    w_victim = (POLICY == 1) ? w_max_way : r_fifo_ptr[r_idx];
    for (int w = WAY_NUM - 1; w >= 0; w--) begin
      if (!r_valid[r_idx][w]) w_victim = WW'(w);
    end
  end

  // An install into an invalid way ages every valid way, as if its old age were the maximum.
  assign w_fill_done = (r_state == FILL) && cm_ReadReady;
  assign w_touch     = ((r_state == COMPARE) && w_hit) || w_fill_done;
  assign w_touch_way = (r_state == COMPARE) ? w_hit_way : r_victim;
  assign w_touch_old = ((r_state == COMPARE) || r_valid[r_idx][r_victim]) ?
                       r_age[r_idx][w_touch_way] : WW'(WAY_NUM - 1);

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_state <= IDLE;
      for (int s = 0; s < SET_NUM; s++) begin
        r_valid[s]    <= '0;
        r_dirty[s]    <= '0;
        r_fifo_ptr[s] <= '0;
        for (int w = 0; w < WAY_NUM; w++) r_age[s][w] <= '0;
      end
      r_rw      <= 1'b0;
      r_req_tag <= '0;
      r_idx     <= '0;
      r_wdata   <= '0;
      r_victim  <= '0;
      r_rdata   <= '0;
    end else begin
      if ((POLICY == 1) && w_touch) begin
        for (int w = 0; w < WAY_NUM; w++) begin
          if (WW'(w) == w_touch_way)
            r_age[r_idx][w] <= '0;
          else if (r_valid[r_idx][w] && (r_age[r_idx][w] < w_touch_old))
            r_age[r_idx][w] <= r_age[r_idx][w] + WW'(1);
        end
      end
      case (r_state)
        IDLE: begin
          if (rc_Valid) begin
            r_rw      <= rc_RW;
            r_req_tag <= rc_Addr[ADDR_WIDTH-1:IDX+OFF];
            r_idx     <= rc_Addr[IDX+OFF-1:OFF];
            r_wdata   <= rc_WriteData;
            r_state   <= COMPARE;
          end
        end
        COMPARE: begin
          if (w_hit) begin
            if (r_rw) r_dirty[r_idx][w_hit_way] <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_victim <= w_victim;
            r_state  <= (r_valid[r_idx][w_victim] && r_dirty[r_idx][w_victim]) ? WBACK : FILL;
          end
        end
        WBACK: begin
          if (cm_WriteReady) r_state <= FILL;
        end
        FILL: begin
          if (cm_ReadReady) begin
            r_valid[r_idx][r_victim] <= 1'b1;
            r_dirty[r_idx][r_victim] <= r_rw;
            r_rdata                  <= r_rw ? r_wdata : cm_ReadData;
            if (w_full) r_fifo_ptr[r_idx] <= r_fifo_ptr[r_idx] + WW'(1);
            r_state <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if ((r_state == COMPARE) && w_hit && r_rw)
      r_data[r_idx][w_hit_way] <= r_wdata;
    if (w_fill_done) begin
      r_tag[r_idx][r_victim]  <= r_req_tag;
      r_data[r_idx][r_victim] <= r_rw ? r_wdata : cm_ReadData;
    end
  end

  assign rc_Done       = ((r_state == COMPARE) && w_hit) || (r_state == DONE);
  assign rc_Hit        = (r_state == COMPARE) && w_hit;
  assign rc_ReadData   = ((r_state == COMPARE) && w_hit && !r_rw) ? r_data[r_idx][w_hit_way] :
                         ((r_state == DONE) && !r_rw) ? r_rdata : '0;
  assign cm_ReadValid  = (r_state == FILL);
  assign cm_ReadAddr   = ADDR_WIDTH'({r_req_tag, r_idx}) << OFF;
  assign cm_WriteValid = (r_state == WBACK);
  assign cm_WriteAddr  = ADDR_WIDTH'({r_tag[r_idx][r_victim], r_idx}) << OFF;
  assign cm_WriteData  = r_data[r_idx][r_victim];

endmodule

// File: tb/tb_cache_set_assoc.sv
// Directed bench: a FIFO and an LRU instance receive identical stimulus; each
// request is driven to completion while a responder answers the cm_ channels.
module tb_cache_set_assoc;
  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic        rc_Valid = 1'b0;
  logic        rc_RW = 1'b0;
  logic [31:0] rc_Addr = '0;
  logic [31:0] rc_WriteData = '0;
  logic        cm_ReadReady = 1'b0;
  logic [31:0] cm_ReadData = '0;
  logic        cm_WriteReady = 1'b0;

  logic [1:0]  done, hit, rvld, wvld;
  logic [31:0] rdata [2];
  logic [31:0] raddr [2];
  logic [31:0] waddr [2];
  logic [31:0] wdat  [2];

  always #5 CLK = ~CLK;

  cache_set_assoc #(.POLICY(0)) u_fifo (
    .CLK(CLK), .Reset(Reset), .rc_Valid(rc_Valid), .rc_RW(rc_RW), .rc_Addr(rc_Addr),
    .rc_WriteData(rc_WriteData), .rc_ReadData(rdata[0]), .rc_Done(done[0]), .rc_Hit(hit[0]),
    .cm_ReadValid(rvld[0]), .cm_ReadAddr(raddr[0]), .cm_ReadReady(cm_ReadReady),
    .cm_ReadData(cm_ReadData), .cm_WriteValid(wvld[0]), .cm_WriteAddr(waddr[0]),
    .cm_WriteData(wdat[0]), .cm_WriteReady(cm_WriteReady)
  );

  cache_set_assoc #(.POLICY(1)) u_lru (
    .CLK(CLK), .Reset(Reset), .rc_Valid(rc_Valid), .rc_RW(rc_RW), .rc_Addr(rc_Addr),
    .rc_WriteData(rc_WriteData), .rc_ReadData(rdata[1]), .rc_Done(done[1]), .rc_Hit(hit[1]),
    .cm_ReadValid(rvld[1]), .cm_ReadAddr(raddr[1]), .cm_ReadReady(cm_ReadReady),
    .cm_ReadData(cm_ReadData), .cm_WriteValid(wvld[1]), .cm_WriteAddr(waddr[1]),
    .cm_WriteData(wdat[1]), .cm_WriteReady(cm_WriteReady)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  bit          got_done [2];
  logic        got_hit  [2];
  logic [31:0] got_rdata[2];
  int          done_cyc [2];
  int          n_wb     [2];
  int          n_fill   [2];
  logic [31:0] wb_addr  [2];
  logic [31:0] wb_dat   [2];
  logic [31:0] fill_addr[2];
  bit          wb_unstable[2];
  bit          overlap  [2];

  logic [31:0] set0_addr [3] = '{32'h60, 32'hA0, 32'hE0};
  logic [31:0] set1_addr [4] = '{32'h04, 32'h14, 32'h24, 32'h34};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Cycle 1 is the cycle rc_Valid is raised; a hit must show rc_Done in cycle 2.
  task automatic do_req(input logic rw, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] md, input int stall);
    int wb_cnt;
    for (int d = 0; d < 2; d++) begin
      got_done[d] = 0; got_hit[d] = 0; got_rdata[d] = '0; done_cyc[d] = 0;
      n_wb[d] = 0; n_fill[d] = 0; wb_addr[d] = '0; wb_dat[d] = '0; fill_addr[d] = '0;
      wb_unstable[d] = 0; overlap[d] = 0;
    end
    wb_cnt = 0;
    @(negedge CLK);
    rc_RW = rw; rc_Addr = addr; rc_WriteData = wd; cm_ReadData = md; rc_Valid = 1'b1;
    for (int c = 2; c < 60 && !(got_done[0] && got_done[1]); c++) begin
      @(negedge CLK);
      cm_ReadReady  = 1'b0;
      cm_WriteReady = 1'b0;
      for (int d = 0; d < 2; d++) begin
        if (done[d] && !got_done[d]) begin
          got_done[d] = 1; done_cyc[d] = c; got_hit[d] = hit[d]; got_rdata[d] = rdata[d];
          rc_Valid = 1'b0;
        end
        if (wvld[d]) begin
          if (n_wb[d] != 0 && (waddr[d] !== wb_addr[d] || wdat[d] !== wb_dat[d])) wb_unstable[d] = 1;
          wb_addr[d] = waddr[d]; wb_dat[d] = wdat[d]; n_wb[d]++;
        end
        if (rvld[d]) begin
          n_fill[d]++; fill_addr[d] = raddr[d];
        end
        if (rvld[d] && wvld[d]) overlap[d] = 1;
      end
      if (wvld != 2'b00) begin
        wb_cnt++;
        if (wb_cnt > stall) cm_WriteReady = 1'b1;
      end
      if (rvld != 2'b00) cm_ReadReady = 1'b1;
    end
    rc_Valid = 1'b0; cm_ReadReady = 1'b0; cm_WriteReady = 1'b0;
  endtask

  task automatic expect_req(input string tag, input logic e_hit, input logic [31:0] e_rd,
                            input bit chk_rd, input int e_cyc, input int e_fill, input int e_wb);
    string t;
    for (int d = 0; d < 2; d++) begin
      t = $sformatf("%s.%s", tag, (d == 0) ? "fifo" : "lru");
      chk({t, ".done"},   32'(got_done[d]), 32'd1);
      chk({t, ".hit"},    32'(got_hit[d]),  32'(e_hit));
      if (chk_rd) chk({t, ".rdata"}, got_rdata[d], e_rd);
      chk({t, ".cycles"}, 32'(done_cyc[d]), 32'(e_cyc));
      chk({t, ".fills"},  32'(n_fill[d]),   32'(e_fill));
      chk({t, ".wbacks"}, 32'(n_wb[d]),     32'(e_wb));
    end
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    Reset = 1'b0;
    repeat (2) @(negedge CLK);
    Reset = 1'b1;
  endtask

  initial begin
    bit seen;
    bit spurious;

    repeat (3) @(negedge CLK);
    chk("reset.done",  32'(done), 32'd0);
    chk("reset.hit",   32'(hit),  32'd0);
    chk("reset.rvld",  32'(rvld), 32'd0);
    chk("reset.wvld",  32'(wvld), 32'd0);
    chk("reset.rdata.fifo", rdata[0], 32'd0);
    chk("reset.rdata.lru",  rdata[1], 32'd0);
    Reset = 1'b1;

    // Cold read miss, then hits on the installed line.
    do_req(1'b0, 32'h10, 32'h0, 32'hAAAA0001, 0);
    expect_req("miss_10", 1'b0, 32'hAAAA0001, 1, 4, 1, 0);
    chk("miss_10.fill_addr.fifo", fill_addr[0], 32'h10);
    chk("miss_10.fill_addr.lru",  fill_addr[1], 32'h10);
    do_req(1'b0, 32'h10, 32'h0, 32'h0, 0);
    expect_req("hit_10", 1'b1, 32'hAAAA0001, 1, 2, 0, 0);
    do_req(1'b1, 32'h10, 32'h55, 32'h0, 0);
    expect_req("whit_10", 1'b1, 32'h0, 0, 2, 0, 0);
    do_req(1'b0, 32'h10, 32'h0, 32'h0, 0);
    expect_req("rehit_10", 1'b1, 32'h55, 1, 2, 0, 0);

    // Ready inputs with no matching valid must not disturb anything.
    @(negedge CLK);
    spurious = 0;
    cm_ReadReady = 1'b1; cm_WriteReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      if ((done | rvld | wvld) != 2'b00) spurious = 1;
    end
    cm_ReadReady = 1'b0; cm_WriteReady = 1'b0;
    chk("idle_ready.quiet", 32'(spurious), 32'd0);
    do_req(1'b0, 32'h10, 32'h0, 32'h0, 0);
    expect_req("idle_ready.hit", 1'b1, 32'h55, 1, 2, 0, 0);

    // Dirty line in set 0 is written back when the set overflows; write-back stalls 5 cycles.
    pulse_reset();
    do_req(1'b1, 32'h20, 32'hDEAD, 32'h1111, 0);
    expect_req("wmiss_20", 1'b0, 32'h0, 0, 4, 1, 0);
    chk("wmiss_20.fill_addr", fill_addr[0], 32'h20);
    for (int i = 0; i < 3; i++) begin
      do_req(1'b0, set0_addr[i], 32'h0, set0_addr[i] << 4, 0);
      expect_req($sformatf("fill_set0_%0d", i), 1'b0, set0_addr[i] << 4, 1, 4, 1, 0);
    end
    do_req(1'b0, 32'h120, 32'h0, 32'h1200, 5);
    expect_req("evict_20", 1'b0, 32'h1200, 1, 10, 1, 6);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("evict_20.wb_addr.%0d", d),  wb_addr[d], 32'h20);
      chk($sformatf("evict_20.wb_data.%0d", d),  wb_dat[d],  32'hDEAD);
      chk($sformatf("evict_20.wb_stable.%0d", d), 32'(wb_unstable[d]), 32'd0);
      chk($sformatf("evict_20.overlap.%0d", d),   32'(overlap[d]), 32'd0);
      chk($sformatf("evict_20.fill_addr.%0d", d), fill_addr[d], 32'h120);
    end
    do_req(1'b0, 32'h20, 32'h0, 32'h2222, 0);
    expect_req("reread_20", 1'b0, 32'h2222, 1, 4, 1, 0);

    // Set 1 policy split: FIFO evicts the oldest install, LRU the least recently used.
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      do_req(1'b1, set1_addr[i], set1_addr[i], 32'h0, 0);
      expect_req($sformatf("wfill_set1_%0d", i), 1'b0, 32'h0, 0, 4, 1, 0);
    end
    do_req(1'b0, 32'h04, 32'h0, 32'h0, 0);
    expect_req("hit_04", 1'b1, 32'h04, 1, 2, 0, 0);
    do_req(1'b0, 32'h44, 32'h0, 32'h4444, 0);
    expect_req("miss_44", 1'b0, 32'h4444, 1, 5, 1, 1);
    chk("miss_44.fifo.wb_addr", wb_addr[0], 32'h04);
    chk("miss_44.fifo.wb_data", wb_dat[0],  32'h04);
    chk("miss_44.lru.wb_addr",  wb_addr[1], 32'h14);
    chk("miss_44.lru.wb_data",  wb_dat[1],  32'h14);

    // Reset while waiting in FILL drops the request and empties the cache.
    @(negedge CLK);
    rc_RW = 1'b0; rc_Addr = 32'h300; cm_ReadData = 32'h3333; rc_Valid = 1'b1;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge CLK);
      if (rvld[0]) seen = 1;
    end
    chk("rst_fill.reached", 32'(seen), 32'd1);
    Reset = 1'b0;
    #1;
    chk("rst_fill.rvld", 32'(rvld), 32'd0);
    chk("rst_fill.wvld", 32'(wvld), 32'd0);
    chk("rst_fill.done", 32'(done), 32'd0);
    rc_Valid = 1'b0;
    @(negedge CLK);
    chk("rst_fill.no_done", 32'(done), 32'd0);
    @(negedge CLK);
    Reset = 1'b1;
    do_req(1'b0, 32'h44, 32'h0, 32'h5555, 0);
    expect_req("post_rst_44", 1'b0, 32'h5555, 1, 4, 1, 0);
    do_req(1'b0, 32'h10, 32'h0, 32'h6666, 0);
    expect_req("post_rst_10", 1'b0, 32'h6666, 1, 4, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
